// File: rtl/charge_fetcher_pkg.sv
// Shared types for the charge-readout path: word address, charge sample, the
// 2-port x 4-bank charge pair and the FIFO entry carried by the fetcher.
package charge_fetcher_pkg;

    localparam int CWIDTH        = 16;
    localparam int AWIDTH        = 16;
    localparam int CHARGE_RD_LAT = 8;

    typedef logic [AWIDTH-1:0]        addr_t;
    typedef logic signed [CWIDTH-1:0] charge_t;
    // Outer index is the port (0 = word 2k, 1 = word 2k+1), inner index the bank
    typedef charge_t [1:0][3:0]       charge_pair_t;

    typedef struct packed {
        charge_pair_t data;
        logic         last;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Sign-extended sum of the eight charges of one pair; three guard bits cover the growth
    function automatic logic signed [CWIDTH+2:0] pair_sum(input charge_pair_t p);
        logic signed [CWIDTH+2:0] acc;
        acc = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = acc + {{3{p[i][j][CWIDTH-1]}}, p[i][j]};
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/charge_fetcher_fifo.sv
// Return buffer of the charge fetcher: synchronous FIFO of {charge pair, last}
// with asynchronous active-low reset. DEPTH must be a power of two, >= 2.
module charge_fifo
    import charge_fetcher_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fifo_entry_t                push_entry,
    input  logic                       pop,
    output fifo_entry_t                head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fifo_entry_t   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Storage and pointers; the fetcher never pushes when full nor pops when empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == '0);

endmodule

// File: rtl/charge_fetcher.sv
// Solver-side charge readout: sweeps the grid with paired 4-bank reads on a fixed
// latency, buffers returns under credit control and streams them out with a last flag.
// Optional feature macro CHARGE_CHECKSUM_EN adds the total_charge output. READ_LAT >= 2.
module charge_fetcher
    import charge_fetcher_pkg::*;
#(
    parameter int NUM_WORDS  = 1024,
    parameter int READ_LAT   = CHARGE_RD_LAT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               valid_req,
    output addr_t [1:0][3:0]   grid_addr,
    input  charge_pair_t       charge_in,
    output logic               m_valid,
    input  logic               m_ready,
    output charge_pair_t       m_data,
    output logic               m_last
`ifdef CHARGE_CHECKSUM_EN
    ,
    output logic signed [CWIDTH+$clog2(8*NUM_WORDS)-1:0] total_charge
`endif
);

    localparam int            KW     = (NUM_WORDS > 2) ? $clog2(NUM_WORDS/2) : 1;
    localparam int            CW     = $clog2(FIFO_DEPTH+1);
    localparam logic [KW-1:0] LAST_K = KW'(NUM_WORDS/2 - 1);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(FIFO_DEPTH);

    fetch_state_t         state_r, state_nxt_s;
    logic [KW-1:0]        k_r, issue_k_s, ret_idx_r;
    logic [CW-1:0]        inflight_r, fifo_count_s;
    logic [READ_LAT-1:0]  dl_r;
    logic                 valid_req_r, busy_r, done_r;
    addr_t [1:0][3:0]     grid_addr_r;
    addr_t                req_a_s, req_b_s;
    logic                 issue_s, accept_start_s, done_s, credit_ok_s;
    logic                 ret_s, pop_s, fifo_empty_s;
    fifo_entry_t          push_entry_s, head_s;

    assign credit_ok_s = (({1'b0, inflight_r} + {1'b0, fifo_count_s}) < DEPTH_L);
    assign ret_s       = dl_r[READ_LAT-1];
    assign pop_s       = !fifo_empty_s && m_ready;
    assign issue_k_s   = accept_start_s ? '0 : k_r;
    assign req_a_s     = AWIDTH'({issue_k_s, 1'b0});
    assign req_b_s     = AWIDTH'({issue_k_s, 1'b1});

    // Next state; a start in IDLE issues request 0 in the same cycle
    always_comb begin
        state_nxt_s    = state_r;
        issue_s        = 1'b0;
        accept_start_s = 1'b0;
        done_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !done_r) begin
                    accept_start_s = 1'b1;
                    issue_s        = 1'b1;
                    state_nxt_s    = (LAST_K == '0) ? ST_DRAIN : ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (credit_ok_s) begin
                    issue_s     = 1'b1;
                    state_nxt_s = (k_r == LAST_K) ? ST_DRAIN : ST_FETCH;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_s.last && (inflight_r == '0) && (fifo_count_s == CW'(1))) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM, request generation, return tracking and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            k_r         <= '0;
            ret_idx_r   <= '0;
            inflight_r  <= '0;
            dl_r        <= '0;
            valid_req_r <= 1'b0;
            grid_addr_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= done_s;
            valid_req_r <= issue_s;
            dl_r        <= {dl_r[READ_LAT-2:0], valid_req_r};
            if (issue_s) begin
                k_r <= issue_k_s + KW'(1);
                for (int b = 0; b < 4; b++) begin
                    grid_addr_r[0][b] <= req_a_s;
                    grid_addr_r[1][b] <= req_b_s;
                end
            end
            if (accept_start_s) begin
                ret_idx_r <= '0;
            end else if (ret_s) begin
                ret_idx_r <= ret_idx_r + KW'(1);
            end
            case ({issue_s, ret_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    assign push_entry_s.data = charge_in;
    assign push_entry_s.last = (ret_idx_r == LAST_K);

    charge_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (ret_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .count      (fifo_count_s),
        .empty      (fifo_empty_s)
    );

`ifdef CHARGE_CHECKSUM_EN
    localparam int TW = CWIDTH + $clog2(8*NUM_WORDS);
    logic signed [CWIDTH+2:0] pair_sum_s;
    logic signed [TW-1:0]     total_r;

    assign pair_sum_s = pair_sum(charge_in);

    // Running sum of every buffered charge, held after done until the next start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_r <= '0;
        end else if (accept_start_s) begin
            total_r <= '0;
        end else if (ret_s) begin
            total_r <= total_r + {{(TW-CWIDTH-3){pair_sum_s[CWIDTH+2]}}, pair_sum_s};
        end else begin
            total_r <= total_r;
        end
    end

    assign total_charge = total_r;
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign valid_req = valid_req_r;
    assign grid_addr = grid_addr_r;
    assign m_valid   = !fifo_empty_s;
    assign m_data    = fifo_empty_s ? '0 : head_s.data;
    assign m_last    = !fifo_empty_s && head_s.last;

endmodule
